// File: rtl/cussen_decoder.sv
// Receive-side inverse of the cussen sort/dedup/delta encoder: prefix-sums the
// delta beats into a sorted value table, then replays the pointers through it.
module cussen_decoder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 9,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_delta,
  input  logic [PTR_W-1:0] in_ptr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             out_last,
  output logic [PTR_W-1:0] uniq_cnt,
  output logic             frame_err
);
  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [DEPTH-1:0][WIDTH-1:0]  tbl;
  logic [DEPTH-1:0][PTR_W-1:0]  ptrs;
  logic                         term;

  logic [PTR_W-1:0] ptr_cur;
  logic [WIDTH-1:0] lookup;
  logic             hit;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);

  // Output beat is a pure function of registered state; in_* never reach out_*.
  always_comb begin
    ptr_cur = ptrs[cnt];
    hit     = (ptr_cur < uniq_cnt);
    lookup  = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ptr_cur == PTR_W'(i)) lookup = tbl[i];
  end

  assign out_data = (out_valid && hit) ? lookup : '0;
  assign out_err  = out_valid && !hit;
  assign out_last = out_valid && (cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      tbl       <= '0;
      ptrs      <= '0;
      uniq_cnt  <= '0;
      term      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          ptrs[cnt] <= in_ptr;
          if (cnt == '0) begin
            tbl[0]    <= in_delta;
            uniq_cnt  <= PTR_W'(1);
            term      <= 1'b0;
            frame_err <= 1'b0;
          end else if (!term) begin
            // A zero delta marks the end of the unique table; later deltas are padding.
            if (in_delta != '0) begin
              tbl[uniq_cnt] <= tbl[uniq_cnt - PTR_W'(1)] + in_delta;
              uniq_cnt      <= uniq_cnt + PTR_W'(1);
            end else begin
              term <= 1'b1;
            end
          end
          if (cnt == LAST_BEAT) begin
            cnt   <= '0;
            state <= EMIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EMIT: begin
          if (!hit) frame_err <= 1'b1;
          if (out_ready) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= LOAD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_cussen_decoder.sv
// Directed frames against a list-based model of the decode, checked every cycle.
module tb_cussen_decoder;
  localparam int WIDTH = 8;
  localparam int DEPTH = 9;
  localparam int PTR_W = 4;

  logic             clk = 0;
  logic             rst = 1;
  logic             in_valid = 0;
  logic             in_ready;
  logic [WIDTH-1:0] in_delta = '0;
  logic [PTR_W-1:0] in_ptr = '0;
  logic             out_valid;
  logic             out_ready = 0;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             out_last;
  logic [PTR_W-1:0] uniq_cnt;
  logic             frame_err;

  cussen_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_delta(in_delta), .in_ptr(in_ptr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .out_last(out_last), .uniq_cnt(uniq_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int oj = 0;

  int cur_d[DEPTH];
  int cur_p[DEPTH];
  int exp_data[DEPTH];
  int exp_err[DEPTH];
  int exp_uniq;
  int exp_ferr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: sorted table is the running sum of deltas up to the first zero delta.
  task automatic build_model();
    int tq[$];
    int sum;
    tq.delete();
    sum = cur_d[0] % 256;
    tq.push_back(sum);
    for (int k = 1; k < DEPTH; k++) begin
      if (cur_d[k] == 0) break;
      sum = (sum + cur_d[k]) % 256;
      tq.push_back(sum);
    end
    exp_uniq = tq.size();
    exp_ferr = 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (cur_p[j] < tq.size()) begin
        exp_data[j] = tq[cur_p[j]];
        exp_err[j]  = 0;
      end else begin
        exp_data[j] = 0;
        exp_err[j]  = 1;
        exp_ferr    = 1;
      end
    end
  endtask

  task automatic set_frame(input int d[DEPTH], input int p[DEPTH]);
    for (int k = 0; k < DEPTH; k++) begin
      cur_d[k] = d[k];
      cur_p[k] = p[k];
    end
    build_model();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready) oj = 0;
      chk("ready_vs_valid", int'(in_ready), int'(!out_valid));
      if (out_valid) begin
        if (oj < DEPTH) begin
          chk($sformatf("out_data[%0d]", oj), out_data, exp_data[oj]);
          chk($sformatf("out_err[%0d]", oj), out_err, exp_err[oj]);
          chk($sformatf("out_last[%0d]", oj), out_last, int'(oj == DEPTH - 1));
          chk("uniq_emit", uniq_cnt, exp_uniq);
        end else begin
          chk("extra_out_beat", 1, 0);
        end
        if (out_ready) oj++;
      end else begin
        chk("idle_data", out_data, 0);
        chk("idle_err", out_err, 0);
        chk("idle_last", out_last, 0);
      end
    end
  end

  task automatic send_frame(input int nb, input int gap, input int stall_beat);
    int n;
    int stall;
    for (int k = 0; k < nb; k++) begin
      if (gap != 0 && (k % 3) == 1) begin
        in_valid = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
      chk("in_ready_load", in_ready, 1);
      in_valid = 1;
      in_delta = WIDTH'(cur_d[k]);
      in_ptr   = PTR_W'(cur_p[k]);
      @(posedge clk); #1;
      in_valid = 0;
      if (k == 0) begin
        chk("uniq_after_b0", uniq_cnt, 1);
        chk("ferr_after_b0", frame_err, 0);
      end
    end
    if (nb < DEPTH) return;
    chk("latency_out_valid", out_valid, 1);
    n = 0;
    stall = 0;
    while (oj < DEPTH && n < 200) begin
      if (oj == stall_beat && stall < 5) begin
        out_ready = 0;
        stall++;
      end else begin
        out_ready = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 0;
    if (n >= 200) chk("drain_timeout", 1, 0);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("uniq_after", uniq_cnt, exp_uniq);
    chk("frame_err_after", frame_err, exp_ferr);
  endtask

  int t1_d[DEPTH] = '{3, 2, 4, 0, 0, 0, 0, 0, 0};
  int t1_p[DEPTH] = '{1, 0, 1, 2, 0, 2, 1, 0, 2};
  int t1_o[DEPTH] = '{5, 3, 5, 9, 3, 9, 5, 3, 9};
  int t2_d[DEPTH] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int t2_p[DEPTH] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
  int t2_o[DEPTH] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int t3_d[DEPTH] = '{200, 100, 0, 0, 0, 0, 0, 0, 0};
  int t3_p[DEPTH] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int t4_p[DEPTH] = '{1, 0, 1, 2, 15, 2, 3, 0, 2};
  int t4_o[DEPTH] = '{5, 3, 5, 9, 0, 9, 0, 3, 9};

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_uniq", uniq_cnt, 0);
    chk("rst_frame_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // T1
    set_frame(t1_d, t1_p);
    for (int j = 0; j < DEPTH; j++) chk("model_t1", exp_data[j], t1_o[j]);
    chk("model_t1_uniq", exp_uniq, 3);
    send_frame(DEPTH, 0, -1);

    // T2
    set_frame(t2_d, t2_p);
    for (int j = 0; j < DEPTH; j++) chk("model_t2", exp_data[j], t2_o[j]);
    send_frame(DEPTH, 0, -1);
    chk("t2_uniq_lit", uniq_cnt, 9);

    // T3: wrap-around in the prefix sum
    set_frame(t3_d, t3_p);
    chk("model_t3_b1", exp_data[1], 44);
    send_frame(DEPTH, 0, -1);
    chk("t3_uniq_lit", uniq_cnt, 2);

    // T4: out-of-range and not-found pointers
    set_frame(t1_d, t4_p);
    for (int j = 0; j < DEPTH; j++) chk("model_t4", exp_data[j], t4_o[j]);
    chk("model_t4_err4", exp_err[4], 1);
    chk("model_t4_err6", exp_err[6], 1);
    send_frame(DEPTH, 0, -1);
    repeat (3) @(posedge clk);
    #1 chk("t4_frame_err_hold", frame_err, 1);
    chk("t4_uniq_hold", uniq_cnt, 3);

    // T5: input gaps and output stall on beat 2; beat 0 clears frame_err
    set_frame(t1_d, t1_p);
    send_frame(DEPTH, 2, 2);

    // T6: reset mid-frame, then a clean T2 frame
    set_frame(t2_d, t2_p);
    send_frame(5, 0, -1);
    rst = 1;
    #1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_uniq", uniq_cnt, 0);
    chk("t6_frame_err", frame_err, 0);
    @(posedge clk); #1;
    rst = 0;
    send_frame(DEPTH, 0, -1);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
